seven_segment_array: RTL and testbench

Multi-digit seven-segment driver for the water dispenser front panel. On a `start` strobe it converts an unsigned binary `value` into decimal with an iterative shift-add-3 (double-dabble) engine. It then drives `DIGITS` active-low segment displays with optional leading-zero blanking, per-digit decimal points and an overflow indication. It sits between the dispenser control logic (volume/price counters) and the board's HEX display pins, and replaces per-digit combinational decoding.

---
 rtl/seven_segment_pkg.sv | 34 +++
 rtl/seven_segment_encoder.sv | 27 ++
 rtl/seven_segment_array.sv | 153 +++++++++++++++
 tb/tb_seven_segment_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants, state encoding and sizing helpers for the seven-segment driver.
package seven_segment_pkg;

  // Active-low segment codes: bit0..bit6 = a..g, bit7 = dp (1 = off)
  localparam logic [7:0] SEG_0     = 8'b1100_0000;
  localparam logic [7:0] SEG_1     = 8'b1111_1001;
  localparam logic [7:0] SEG_2     = 8'b1010_0100;
  localparam logic [7:0] SEG_3     = 8'b1011_0000;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b1001_0010;
  localparam logic [7:0] SEG_6     = 8'b1000_0010;
  localparam logic [7:0] SEG_7     = 8'b1111_1000;
  localparam logic [7:0] SEG_8     = 8'b1000_0000;
  localparam logic [7:0] SEG_9     = 8'b1001_0000;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;
  localparam logic [7:0] SEG_DASH  = 8'b1011_1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ENCODE = 2'd2
  } state_e;

  // Number of BCD nibbles needed to hold 2^width-1
  function automatic int bcd_digits(input int width);
    return (width * 3) / 10 + 1;
  endfunction

  // Width of a counter that can hold the value width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seven_segment_encoder.sv
// Combinational BCD nibble to active-low segment code (dp off).
module seven_segment_encoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  // Table lookup; non-decimal nibbles cannot occur but display blank
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_array.sv
// Multi-digit seven-segment driver: iterative double-dabble binary to BCD,
// then per-digit encoding with leading-zero blanking, dp and overflow dashes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; display holds last result
// ST_SHIFT  | one add-3/shift step per cycle, WIDTH steps in total
// ST_ENCODE | BCD final; register display and pulse done
module seven_segment_array
  import seven_segment_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic [DIGITS-1:0]     point,
  input  logic                  blank_zeros,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   display
);

  localparam int BCD_DIGITS = bcd_digits(WIDTH);
  localparam int BW         = 4 * BCD_DIGITS;
  localparam int CW         = cnt_width(WIDTH);

  state_e               state_q;
  logic [WIDTH-1:0]     bin_q;
  logic [BW-1:0]        bcd_q;
  logic [CW-1:0]        cnt_q;
  logic [DIGITS-1:0]    point_q;
  logic                 blank_q;
  logic                 busy_q;
  logic                 done_q;
  logic [8*DIGITS-1:0]  display_q;

  logic [BW-1:0]        bcd_adj;
  logic [BW+WIDTH-1:0]  shifted;
  logic [BW-1:0]        bcd_d;
  logic [WIDTH-1:0]     bin_d;
  logic [8*DIGITS-1:0]  display_d;
  logic                 ovf;
  logic                 seen;
  logic [7:0]           code;

  logic [3:0]           digit_nib [DIGITS];
  logic [7:0]           seg_code  [DIGITS];

  // Add 3 to every nibble >= 5 before the shift so it carries correctly
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {bcd_adj, bin_q} << 1;
  assign bcd_d   = shifted[BW+WIDTH-1:WIDTH];
  assign bin_d   = shifted[WIDTH-1:0];

  // Physical digits beyond the BCD width always read as zero
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g < BCD_DIGITS) begin : g_bcd
      assign digit_nib[g] = bcd_q[4*g +: 4];
    end else begin : g_zero
      assign digit_nib[g] = 4'd0;
    end
    seven_segment_encoder u_enc (
      .nibble_i (digit_nib[g]),
      .seg_o    (seg_code[g])
    );
  end

  // Overflow when any nibble that has no physical display is nonzero
  always_comb begin
    ovf = 1'b0;
    for (int i = DIGITS; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ovf = 1'b1;
    end
  end

  // Scan from the top digit down; a digit is a leading zero until a nonzero
  // nibble or an enabled dp has been seen at or above it
  always_comb begin
    seen      = 1'b0;
    code      = SEG_BLANK;
    display_d = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (digit_nib[i] != 4'd0) | point_q[i];
      code = seg_code[i];
      if (ovf) begin
        code = SEG_DASH;
      end else begin
        if (blank_q && !seen && (i != 0)) code = SEG_BLANK;
        if (point_q[i]) code[7] = 1'b0;
      end
      display_d[8*i +: 8] = code;
    end
  end

  // Conversion FSM with registered busy/done/display
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      point_q   <= '0;
      blank_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      display_q <= '1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q   <= value;
            point_q <= point;
            blank_q <= blank_zeros;
            bcd_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_ENCODE;
        end
        ST_ENCODE: begin
          display_q <= display_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign display = display_q;

endmodule

// File: tb/tb_seven_segment_array.sv
// Scoreboard bench: two instances (4 and 6 digits) share stimulus; expected
// displays come from a decimal-division model and are checked on each done.
module tb_seven_segment_array;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH + 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  value = '0;
  logic [5:0]        point6 = '0;
  logic              blank_zeros = 1'b0;
  logic              busy4, done4, busy6, done6;
  logic [31:0]       display4;
  logic [47:0]       display6;

  int                n_chk = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                busy_cnt = 0;
  logic [47:0]       last4 = '0;

  typedef struct {
    logic [47:0] e4;
    logic [47:0] e6;
    int          edge0;
  } exp_t;
  exp_t sb[$];

  logic [7:0] seg_tab [10];

  seven_segment_array #(.WIDTH(WIDTH), .DIGITS(4)) dut4 (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .value       (value),
    .point       (point6[3:0]),
    .blank_zeros (blank_zeros),
    .busy        (busy4),
    .done        (done4),
    .display     (display4)
  );

  seven_segment_array #(.WIDTH(WIDTH), .DIGITS(6)) dut6 (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .value       (value),
    .point       (point6),
    .blank_zeros (blank_zeros),
    .busy        (busy6),
    .done        (done6),
    .display     (display6)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [47:0] model(input int unsigned v, input logic [5:0] p,
                                        input bit b, input int nd);
    int          d [10];
    int unsigned tmp, lim;
    int          m;
    bit          ovf;
    logic [7:0]  c;
    logic [47:0] r;
    tmp = v;
    for (int i = 0; i < 10; i++) begin
      d[i] = int'(tmp % 10);
      tmp  = tmp / 10;
    end
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf = (v >= lim);
    m = 0;
    for (int i = 0; i < nd; i++) begin
      if (d[i] != 0 && i > m) m = i;
      if (p[i] && i > m) m = i;
    end
    r = '0;
    for (int i = 0; i < nd; i++) begin
      if (ovf) c = 8'hBF;
      else begin
        c = (b && i > m) ? 8'hFF : seg_tab[d[i]];
        if (p[i]) c[7] = 1'b0;
      end
      r[8*i +: 8] = c;
    end
    return r;
  endfunction

  // Call at a negedge: presents one start pulse and records the expectation
  task automatic drive(input int unsigned v, input logic [5:0] p, input bit b);
    exp_t e;
    value       = WIDTH'(v);
    point6      = p;
    blank_zeros = b;
    start       = 1'b1;
    e.e4    = model(v, p, b, 4);
    e.e6    = model(v, p, b, 6);
    e.edge0 = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Start pulse that the DUT must ignore (issued while busy)
  task automatic poke_busy(input int unsigned v);
    check("busy_before_poke", {47'd0, busy4}, 48'd1);
    value  = WIDTH'(v);
    point6 = 6'b101010;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    value  = '0;
  endtask

  task automatic wait_done;
    for (int k = 0; k < 3 * LAT; k++) begin
      if (done4) break;
      @(negedge clock);
    end
    check("done_seen", {47'd0, done4}, 48'd1);
  endtask

  // Scoreboard consumer and busy/done timing checks
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy4) busy_cnt = busy_cnt + 1;
      check("done_agree", {47'd0, done6}, {47'd0, done4});
      if (done4) begin
        if (sb.size() == 0) begin
          check("spurious_done", {47'd0, done4}, 48'd0);
        end else begin
          e = sb.pop_front();
          check("display4", {16'd0, display4}, e.e4);
          check("display6", display6, e.e6);
          check("latency", 48'(cyc - e.edge0), 48'(LAT));
          check("busy_cycles", 48'(busy_cnt), 48'(LAT));
          last4 = e.e4;
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    repeat (3) @(negedge clock);
    check("rst_display4", {16'd0, display4}, 48'h0000_FFFF_FFFF);
    check("rst_display6", display6, 48'hFFFF_FFFF_FFFF);
    check("rst_busy", {47'd0, busy4}, 48'd0);
    check("rst_done", {47'd0, done4}, 48'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    drive(0, 6'b000000, 1'b1);
    wait_done();
    repeat (4) @(negedge clock);
    check("hold_display", {16'd0, display4}, last4);

    drive(1234, 6'b000000, 1'b0);
    wait_done();
    @(negedge clock);
    drive(5, 6'b000100, 1'b1);
    wait_done();
    @(negedge clock);
    drive(65535, 6'b000000, 1'b0);
    wait_done();
    @(negedge clock);
    drive(65535, 6'b000000, 1'b1);
    wait_done();
    @(negedge clock);
    drive(42, 6'b000001, 1'b1);
    wait_done();
    @(negedge clock);
    drive(9999, 6'b100000, 1'b1);
    wait_done();
    @(negedge clock);
    drive(10000, 6'b000010, 1'b1);
    wait_done();

    // Ignored start while busy, then back-to-back start in the done cycle
    @(negedge clock);
    drive(4321, 6'b000010, 1'b0);
    repeat (5) @(negedge clock);
    poke_busy(777);
    wait_done();
    drive(987, 6'b000000, 1'b1);
    wait_done();
    drive(60, 6'b001000, 1'b1);
    wait_done();

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      drive($urandom_range(0, 65535), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      wait_done();
    end

    // Reset mid-conversion aborts without done
    @(negedge clock);
    drive(3141, 6'b000000, 1'b0);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    @(negedge clock);
    check("abort_busy", {47'd0, busy4}, 48'd0);
    check("abort_done", {47'd0, done4}, 48'd0);
    check("abort_display4", {16'd0, display4}, 48'h0000_FFFF_FFFF);
    check("abort_display6", display6, 48'hFFFF_FFFF_FFFF);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2 * LAT) @(negedge clock);
    check("abort_no_update", {16'd0, display4}, 48'h0000_FFFF_FFFF);

    drive(808, 6'b000100, 1'b1);
    wait_done();
    repeat (3) @(negedge clock);
    check("scoreboard_empty", 48'(sb.size()), 48'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
